ame_num_normal_mc: RTL and testbench

- Multi-lane signed-integer normaliser for the AME datapath: divides each lane by 2^shift using sign-magnitude arithmetic, then applies a selectable rounding mode and saturates to a narrower output width.
- Iterative shifter: shifts STEP_BITS positions per cycle, shared across all lanes.
- valid/ready handshake on both the input and output sides, so it drops into a streaming pipeline without external init/done sequencing.

---
 rtl/ame_num_normal_mc.sv | 150 +++++++++++++++
 tb/tb_ame_num_normal_mc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ame_num_normal_mc.sv
// Multi-lane sign-magnitude normaliser: divides each lane by 2^shift, rounds, and saturates to OUT_BITS.
// Latency ceil(shift/STEP_BITS)+1 cycles; one beat in flight, in_ready_o low until the result is taken.
module ame_num_normal_mc #(
  parameter int DATA_BITS = 64,
  parameter int OUT_BITS  = 32,
  parameter int LANES     = 4,
  parameter int STEP_BITS = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [LANES*DATA_BITS-1:0]    in_data_i,
  input  logic [$clog2(DATA_BITS)-1:0]  in_shift_i,
  input  logic                          in_rnd_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [LANES*OUT_BITS-1:0]     out_data_o,
  output logic [LANES-1:0]              out_sat_o
);

  localparam int SW = $clog2(DATA_BITS);
  localparam logic [DATA_BITS:0] NEG_LIM =
    {{(DATA_BITS+1-OUT_BITS){1'b0}}, 1'b1, {(OUT_BITS-1){1'b0}}};
  localparam logic [DATA_BITS:0] POS_LIM = NEG_LIM - 1'b1;
  localparam logic [OUT_BITS-1:0] OUT_MAX = {1'b0, {(OUT_BITS-1){1'b1}}};
  localparam logic [OUT_BITS-1:0] OUT_MIN = {1'b1, {(OUT_BITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, OUT} state_e;

  state_e                     state_q, state_d;
  logic [DATA_BITS-1:0]       mag_q [LANES];
  logic [DATA_BITS-1:0]       mag_d [LANES];
  logic [LANES-1:0]           sign_q, sign_d;
  logic [LANES-1:0]           rbit_q, rbit_d;
  logic [LANES-1:0]           sticky_q, sticky_d;
  logic [SW-1:0]              rem_q, rem_d;
  logic                       rnd_q, rnd_d;
  logic                       out_valid_q, out_valid_d;
  logic [LANES*OUT_BITS-1:0]  out_data_q, out_data_d;
  logic [LANES-1:0]           out_sat_q, out_sat_d;

  logic [SW-1:0]              step_n;
  logic [DATA_BITS-1:0]       low_mask;
  logic [DATA_BITS:0]         r_w [LANES];

  // Bits below the round bit of this step; empty when step_n == 1.
  assign step_n   = (int'(rem_q) > STEP_BITS) ? SW'(STEP_BITS) : rem_q;
  assign low_mask = (DATA_BITS'(1) << (step_n - SW'(1))) - DATA_BITS'(1);

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      r_w[k] = {1'b0, mag_q[k]} + (DATA_BITS+1)'(rnd_q & rbit_q[k]);
    end
  end

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    sign_d      = sign_q;
    rbit_d      = rbit_q;
    sticky_d    = sticky_q;
    rem_d       = rem_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          for (int k = 0; k < LANES; k++) begin
            sign_d[k] = in_data_i[k*DATA_BITS + DATA_BITS - 1];
            mag_d[k]  = sign_d[k] ? DATA_BITS'(0) - in_data_i[k*DATA_BITS +: DATA_BITS]
                                  : in_data_i[k*DATA_BITS +: DATA_BITS];
          end
          rbit_d   = '0;
          sticky_d = '0;
          rem_d    = in_shift_i;
          rnd_d    = in_rnd_i;
          state_d  = (in_shift_i != '0) ? SHIFT : ROUND;
        end
      end
      SHIFT: begin
        for (int k = 0; k < LANES; k++) begin
          mag_d[k]    = mag_q[k] >> step_n;
          rbit_d[k]   = mag_q[k][step_n - SW'(1)];
          sticky_d[k] = sticky_q[k] | rbit_q[k] | (|(mag_q[k] & low_mask));
        end
        rem_d = rem_q - step_n;
        if (rem_q == step_n) state_d = ROUND;
      end
      ROUND: begin
        for (int k = 0; k < LANES; k++) begin
          if (!sign_q[k] && r_w[k] > POS_LIM) begin
            out_data_d[k*OUT_BITS +: OUT_BITS] = OUT_MAX;
            out_sat_d[k] = 1'b1;
          end else if (sign_q[k] && r_w[k] > NEG_LIM) begin
            out_data_d[k*OUT_BITS +: OUT_BITS] = OUT_MIN;
            out_sat_d[k] = 1'b1;
          end else begin
            out_data_d[k*OUT_BITS +: OUT_BITS] = sign_q[k] ? OUT_BITS'(0) - r_w[k][OUT_BITS-1:0]
                                                           : r_w[k][OUT_BITS-1:0];
            out_sat_d[k] = 1'b0;
          end
        end
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      for (int k = 0; k < LANES; k++) mag_q[k] <= '0;
      sign_q      <= '0;
      rbit_q      <= '0;
      sticky_q    <= '0;
      rem_q       <= '0;
      rnd_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      sign_q      <= sign_d;
      rbit_q      <= rbit_d;
      sticky_q    <= sticky_d;
      rem_q       <= rem_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_ame_num_normal_mc.sv
// Bench for ame_num_normal_mc: directed and random beats against an arithmetic reference model.
module tb_ame_num_normal_mc;

  localparam int DB = 64;
  localparam int OB = 32;
  localparam int NL = 4;
  localparam int SB = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [NL*DB-1:0]   in_data;
  logic [5:0]         in_shift;
  logic               in_rnd;
  logic               out_valid;
  logic               out_ready;
  logic [NL*OB-1:0]   out_data;
  logic [NL-1:0]      out_sat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ame_num_normal_mc #(.DATA_BITS(DB), .OUT_BITS(OB), .LANES(NL), .STEP_BITS(SB)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_shift_i(in_shift), .in_rnd_i(in_rnd),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_sat_o(out_sat)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Divide |x| by 2^s, optionally round half away from zero, then saturate.
  function automatic void model(input logic [63:0] x, input int s, input bit rnd,
                                output logic [31:0] y, output bit sat);
    bit          neg;
    logic [64:0] m, q, r;
    neg = x[63];
    m   = {1'b0, neg ? 64'(64'd0 - x) : x};
    q   = m >> s;
    r   = m - (q << s);
    if (rnd && s > 0 && (r << 1) >= (65'd1 << s)) q = q + 65'd1;
    sat = 1'b0;
    if (!neg && q > 65'h7fff_ffff) begin
      y = 32'h7fff_ffff; sat = 1'b1;
    end else if (neg && q > 65'h8000_0000) begin
      y = 32'h8000_0000; sat = 1'b1;
    end else begin
      y = neg ? 32'(65'd0 - q) : 32'(q);
    end
  endfunction

  task automatic run_beat(input string tag, input logic [NL*DB-1:0] din, input int s,
                          input bit rnd, input int hold);
    logic [NL*OB-1:0] exp_d;
    logic [NL-1:0]    exp_s;
    logic [31:0]      y;
    bit               sat, seen, stable;
    int               lat;
    logic [NL*OB-1:0] snap_d;
    logic [NL-1:0]    snap_s;
    for (int k = 0; k < NL; k++) begin
      model(din[k*DB +: DB], s, rnd, y, sat);
      exp_d[k*OB +: OB] = y;
      exp_s[k] = sat;
    end
    @(negedge clk);
    check_val({tag, "/in_rdy"}, 64'(in_ready), 64'd1);
    in_data  = din;
    in_shift = 6'(s);
    in_rnd   = rnd;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    in_shift = 6'($urandom);
    in_rnd   = 1'($urandom);
    lat  = 0;
    seen = 1'b0;
    while (lat < 200 && !seen) begin
      @(posedge clk); #1;
      lat++;
      seen = out_valid;
    end
    check_val({tag, "/latency"}, seen ? 64'(lat) : 64'hffff, 64'((s + SB - 1) / SB + 1));
    if (!seen) return;
    check_val({tag, "/data"}, 64'(out_data), 64'(exp_d));
    check_val({tag, "/sat"}, 64'(out_sat), 64'(exp_s));
    snap_d = out_data;
    snap_s = out_sat;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (out_data !== snap_d || out_sat !== snap_s || out_valid !== 1'b1 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    if (hold > 0) check_val({tag, "/hold"}, 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val({tag, "/vld_drop"}, 64'(out_valid), 64'd0);
    check_val({tag, "/rdy_back"}, 64'(in_ready), 64'd1);
    check_val({tag, "/data_kept"}, 64'(out_data), 64'(exp_d));
  endtask

  function automatic logic [63:0] rand_lane();
    logic [63:0] v;
    case ($urandom_range(0, 9))
      0: v = 64'h8000_0000_0000_0000;
      1: v = 64'h0;
      default: begin
        v = {$urandom, $urandom};
        v = v >> $urandom_range(0, 63);
        if ($urandom_range(0, 1) == 1) v = 64'd0 - v;
      end
    endcase
    return v;
  endfunction

  function automatic logic [NL*DB-1:0] pack4(input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c, input logic [63:0] d);
    return {d, c, b, a};
  endfunction

  initial begin
    logic [NL*DB-1:0] din;
    bit               seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shift  = '0;
    in_rnd    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst/in_rdy", 64'(in_ready), 64'd1);
    check_val("rst/out_vld", 64'(out_valid), 64'd0);
    check_val("rst/out_dat", 64'(out_data), 64'd0);
    check_val("rst/out_sat", 64'(out_sat), 64'd0);
    rst_n = 1'b1;

    din = pack4(64'd100, -64'sd100, 64'd7, -64'sd8);
    run_beat("trunc", din, 4, 1'b0, 0);
    run_beat("round", din, 4, 1'b1, 0);
    din = pack4(64'd1 << 40, 64'd0 - (64'd1 << 40), 64'h7fff_ffff, 64'hffff_ffff_8000_0000);
    run_beat("sat0", din, 0, 1'b0, 0);
    din = pack4(64'h8000_0000_0000_0000, 64'd255, -64'sd384, 64'd0);
    run_beat("mneg63", din, 63, 1'b0, 0);
    run_beat("mneg20", din, 20, 1'b1, 0);
    din = pack4(64'd1000, -64'sd1000, 64'd3, -64'sd5);
    run_beat("bp", din, 9, 1'b1, 10);

    // Abort in the third SHIFT cycle of a 40-position shift.
    @(negedge clk);
    in_data  = pack4(64'd12345, 64'd1, 64'd2, 64'd3);
    in_shift = 6'd40;
    in_rnd   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("abort/out_vld", 64'(out_valid), 64'd0);
    check_val("abort/in_rdy", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    check_val("abort/no_result", 64'(seen), 64'd0);
    din = pack4(-64'sd48, 64'd49, 64'd1 << 62, 64'd0 - (64'd1 << 45));
    run_beat("after_abort", din, 13, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      din = pack4(rand_lane(), rand_lane(), rand_lane(), rand_lane());
      run_beat($sformatf("rnd%0d", i), din, $urandom_range(0, 63), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
